ir_servo_sequencer: RTL and testbench

IR_SERVO_SEQUENCER -- requirements
Module: ir_servo_sequencer

---
 rtl/ir_servo_sequencer.sv | 135 +++++++++++++
 tb/tb_ir_servo_sequencer.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ir_servo_sequencer.sv
// Servo-arm IR beacon sequencer: deploys the arm, counts IR edges over a fixed
// window, classifies the beacon frequency, then retracts and reports done.
module ir_servo_sequencer #(
  parameter int SERVO_PERIOD  = 2_000_000,
  parameter int PULSE_RETRACT = 100_000,
  parameter int PULSE_DEPLOY  = 200_000,
  parameter int SETTLE_CYCLES = 50_000_000,
  parameter int WINDOW_CYCLES = 1_000_000,
  parameter int LOW_MIN       = 5,
  parameter int HIGH_MIN      = 50
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic       reset_module,
  input  logic       ir_in,
  output logic       done,
  output logic       servo_pwm,
  output logic [1:0] freq_code
);

  localparam int TMR_MAX = (SETTLE_CYCLES > WINDOW_CYCLES) ? SETTLE_CYCLES : WINDOW_CYCLES;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);
  localparam int PW_MAX  = (PULSE_DEPLOY > PULSE_RETRACT) ? PULSE_DEPLOY : PULSE_RETRACT;
  localparam int FRM_MAX = (SERVO_PERIOD > PW_MAX) ? SERVO_PERIOD : PW_MAX;
  localparam int FRM_W   = $clog2(FRM_MAX + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DEPLOY,
    S_MEASURE,
    S_RETRACT,
    S_DONE
  } state_t;

  state_t             state, state_nxt;
  logic [TMR_W-1:0]   tmr;
  logic [7:0]         edge_cnt, edge_cnt_nxt;
  logic [FRM_W-1:0]   frame_cnt;
  logic [FRM_W-1:0]   pulse_w;
  logic               ir_sync_p0, ir_sync_p1, ir_prev_p2;
  logic               ir_rise;
  logic               settle_end, window_end, latch_freq;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  function automatic logic [1:0] classify(input logic [7:0] c);
    if (int'(c) >= HIGH_MIN)     return 2'd2;
    else if (int'(c) >= LOW_MIN) return 2'd1;
    else                         return 2'd0;
  endfunction

  // Stage p0/p1: two-flop synchronizer; p2 holds the previous synchronized sample
  always_ff @(posedge clk) begin
    if (reset) begin
      ir_sync_p0 <= 1'b0;
      ir_sync_p1 <= 1'b0;
      ir_prev_p2 <= 1'b0;
    end else begin
      ir_sync_p0 <= ir_in;
      ir_sync_p1 <= ir_sync_p0;
      ir_prev_p2 <= ir_sync_p1;
    end
  end

  assign ir_rise      = ir_sync_p1 & ~ir_prev_p2;
  assign settle_end   = (tmr == TMR_W'(SETTLE_CYCLES - 1));
  assign window_end   = (tmr == TMR_W'(WINDOW_CYCLES - 1));
  assign edge_cnt_nxt = ir_rise ? sat_inc(edge_cnt) : edge_cnt;

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    latch_freq = 1'b0;
    case (state)
      S_IDLE:    if (enable && !reset_module) state_nxt = S_DEPLOY;
      S_DEPLOY: begin
        if (reset_module)    state_nxt = S_IDLE;
        else if (settle_end) state_nxt = S_MEASURE;
      end
      S_MEASURE: begin
        if (reset_module) begin
          state_nxt = S_IDLE;
        end else if (window_end) begin
          state_nxt  = S_RETRACT;
          latch_freq = 1'b1;
        end
      end
      S_RETRACT: begin
        if (reset_module)    state_nxt = S_IDLE;
        else if (settle_end) state_nxt = S_DONE;
      end
      S_DONE:    if (reset_module) state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  // The timer restarts from zero on every state change, so each phase counts from 0
  always_ff @(posedge clk) begin
    if (reset) begin
      tmr       <= '0;
      edge_cnt  <= '0;
      freq_code <= 2'd0;
      done      <= 1'b0;
    end else begin
      if (state_nxt != state || state == S_IDLE || state == S_DONE) tmr <= '0;
      else                                                         tmr <= tmr + 1'b1;

      edge_cnt <= (state == S_MEASURE) ? edge_cnt_nxt : 8'd0;

      if (state_nxt == S_IDLE) freq_code <= 2'd0;
      else if (latch_freq)     freq_code <= classify(edge_cnt_nxt);

      // One cycle after entering DONE, matching the overall enable-to-done latency
      done <= (state == S_DONE) && (state_nxt == S_DONE);
    end
  end

  always_ff @(posedge clk) begin
    if (reset)                                     frame_cnt <= '0;
    else if (frame_cnt == FRM_W'(SERVO_PERIOD - 1)) frame_cnt <= '0;
    else                                           frame_cnt <= frame_cnt + 1'b1;
  end

  assign pulse_w   = (state == S_DEPLOY || state == S_MEASURE) ? FRM_W'(PULSE_DEPLOY)
                                                               : FRM_W'(PULSE_RETRACT);
  assign servo_pwm = ~reset & (frame_cnt < pulse_w);

endmodule

// File: tb/tb_ir_servo_sequencer.sv
// Randomized self-checking bench for ir_servo_sequencer with a window-level
// reference model of the edge count and frequency classification.
module tb_ir_servo_sequencer;

  localparam int P    = 100;
  localparam int PR   = 5;
  localparam int PD   = 10;
  localparam int S    = 20;
  localparam int W    = 200;
  localparam int LMIN = 5;
  localparam int HMIN = 50;
  localparam int LAT  = 2 * S + W + 1;

  logic       clk;
  logic       reset;
  logic       enable;
  logic       reset_module;
  logic       ir_in;
  logic       done;
  logic       servo_pwm;
  logic [1:0] freq_code;

  int checks;
  int errors;

  ir_servo_sequencer #(
    .SERVO_PERIOD (P),
    .PULSE_RETRACT(PR),
    .PULSE_DEPLOY (PD),
    .SETTLE_CYCLES(S),
    .WINDOW_CYCLES(W),
    .LOW_MIN      (LMIN),
    .HIGH_MIN     (HMIN)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .reset_module(reset_module),
    .ir_in       (ir_in),
    .done        (done),
    .servo_pwm   (servo_pwm),
    .freq_code   (freq_code)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Expected class from the IR samples fed on each edge: the synchronizer shows
  // the value driven at edge j-2, so an edge is seen at edge k when ir[k-2]=1, ir[k-3]=0.
  function automatic int model_freq(input int ir_arr[LAT+1]);
    int cnt;
    cnt = 0;
    for (int k = S + 1; k <= S + W; k++)
      if (ir_arr[k-2] == 1 && ir_arr[k-3] == 0 && cnt < 255) cnt++;
    if (cnt >= HMIN)      return 2;
    else if (cnt >= LMIN) return 1;
    else                  return 0;
  endfunction

  // Full enable-to-done run; mode 0 = ir low, 1 = square wave of given half period, 2 = random
  task automatic run_sequence(input int mode, input int half);
    int ir_arr[LAT+1];
    int pwm_hi;
    int fexp;
    int v;
    pwm_hi = 0;
    for (int e = 0; e <= LAT; e++) begin
      enable = (e == 0) ? 1'b1 : ($urandom_range(0, 7) == 0);
      case (mode)
        0:       v = 0;
        1:       v = (e / half) % 2;
        default: v = int'($urandom_range(0, 1));
      endcase
      ir_in     = v[0];
      ir_arr[e] = v;
      step();
      if (e >= S && e < S + 100 && servo_pwm) pwm_hi++;
      if (e == S + W - 1) begin
        checks++;
        if (freq_code !== 2'd0) begin
          errors++;
          $display("FAIL freq_before_latch: got %0d expected 0", freq_code);
        end
      end
      if (e == LAT - 1) begin
        checks++;
        if (done !== 1'b0) begin
          errors++;
          $display("FAIL done_early: got %0b expected 0 at cycle %0d", done, e);
        end
      end
      if (e == LAT) begin
        checks++;
        if (done !== 1'b1) begin
          errors++;
          $display("FAIL done_latency: got %0b expected 1 at cycle %0d", done, e);
        end
      end
    end
    enable = 1'b0;
    ir_in  = 1'b0;
    fexp   = model_freq(ir_arr);
    checks++;
    if (freq_code !== fexp[1:0]) begin
      errors++;
      $display("FAIL freq_code_model: got %0d expected %0d (mode %0d half %0d)",
               freq_code, fexp, mode, half);
    end
    checks++;
    if (pwm_hi !== PD) begin
      errors++;
      $display("FAIL pwm_measure: got %0d high cycles expected %0d", pwm_hi, PD);
    end
  endtask

  task automatic clear_done();
    reset_module = 1'b1;
    step();
    reset_module = 1'b0;
    checks++;
    if (done !== 1'b0 || freq_code !== 2'd0) begin
      errors++;
      $display("FAIL clear: got done=%0b freq=%0d expected done=0 freq=0", done, freq_code);
    end
  endtask

  task automatic test_reset();
    int n;
    reset = 1'b1; enable = 1'b1; reset_module = 1'b0; ir_in = 1'b1;
    for (int i = 0; i < 3; i++) step();
    checks++;
    if (done !== 1'b0 || freq_code !== 2'd0 || servo_pwm !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: got done=%0b freq=%0d pwm=%0b expected 0 0 0",
               done, freq_code, servo_pwm);
    end
    enable = 1'b0; ir_in = 1'b0;
    reset  = 1'b0;
    #1;
    for (n = 0; n < 6; n++) begin
      checks++;
      if (servo_pwm !== (n < PR)) begin
        errors++;
        $display("FAIL pwm_after_reset: got %0b expected %0b at frame %0d",
                 servo_pwm, (n < PR), n);
      end
      step();
    end
  endtask

  task automatic test_high_freq();
    run_sequence(1, 2);
    checks++;
    if (freq_code !== 2'd2) begin
      errors++;
      $display("FAIL high_freq: got %0d expected 2", freq_code);
    end
    clear_done();
  endtask

  task automatic test_low_freq();
    run_sequence(1, 10);
    checks++;
    if (freq_code !== 2'd1) begin
      errors++;
      $display("FAIL low_freq: got %0d expected 1", freq_code);
    end
    clear_done();
  endtask

  task automatic test_no_ir();
    int hi;
    run_sequence(0, 1);
    checks++;
    if (freq_code !== 2'd0) begin
      errors++;
      $display("FAIL no_ir_freq: got %0d expected 0", freq_code);
    end
    hi = 0;
    for (int i = 0; i < P; i++) begin
      step();
      if (servo_pwm) hi++;
    end
    checks++;
    if (hi !== PR || done !== 1'b1) begin
      errors++;
      $display("FAIL pwm_done: got %0d high done=%0b expected %0d high done=1", hi, done, PR);
    end
    clear_done();
  endtask

  task automatic test_random();
    for (int r = 0; r < 6; r++) begin
      if (r % 3 == 2) run_sequence(2, 1);
      else            run_sequence(1, int'($urandom_range(1, 25)));
      clear_done();
    end
  endtask

  task automatic test_abort();
    int hi, done_seen;
    enable = 1'b1;
    step();
    enable = 1'b0;
    for (int i = 0; i < S + 50; i++) begin
      ir_in = $urandom_range(0, 1);
      step();
    end
    reset_module = 1'b1;
    step();
    reset_module = 1'b0;
    ir_in = 1'b0;
    checks++;
    if (done !== 1'b0 || freq_code !== 2'd0) begin
      errors++;
      $display("FAIL abort_outputs: got done=%0b freq=%0d expected 0 0", done, freq_code);
    end
    hi = 0; done_seen = 0;
    for (int i = 0; i < LAT + 10; i++) begin
      step();
      if (i < P && servo_pwm) hi++;
      if (done) done_seen++;
    end
    checks++;
    if (hi !== PR) begin
      errors++;
      $display("FAIL abort_pwm: got %0d high cycles expected %0d", hi, PR);
    end
    checks++;
    if (done_seen !== 0) begin
      errors++;
      $display("FAIL abort_done: got %0d done cycles expected 0", done_seen);
    end
  endtask

  task automatic test_enable_and_clear();
    int hi, done_seen;
    enable = 1'b1; reset_module = 1'b1;
    step();
    enable = 1'b0; reset_module = 1'b0;
    hi = 0; done_seen = 0;
    for (int i = 0; i < LAT + 10; i++) begin
      step();
      if (i < P && servo_pwm) hi++;
      if (done) done_seen++;
    end
    checks++;
    if (hi !== PR || done_seen !== 0) begin
      errors++;
      $display("FAIL enable_and_clear: got %0d high %0d done expected %0d high 0 done",
               hi, done_seen, PR);
    end
  endtask

  task automatic test_reset_mid_deploy();
    int done_seen;
    enable = 1'b1;
    step();
    enable = 1'b0;
    for (int i = 0; i < 5; i++) step();
    reset = 1'b1;
    step();
    checks++;
    if (done !== 1'b0 || freq_code !== 2'd0 || servo_pwm !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_deploy: got done=%0b freq=%0d pwm=%0b expected 0 0 0",
               done, freq_code, servo_pwm);
    end
    reset = 1'b0;
    done_seen = 0;
    for (int i = 0; i < LAT + 10; i++) begin
      step();
      if (done) done_seen++;
    end
    checks++;
    if (done_seen !== 0) begin
      errors++;
      $display("FAIL reset_mid_deploy_idle: got %0d done cycles expected 0", done_seen);
    end
  endtask

  task automatic test_back_to_back();
    run_sequence(2, 1);
    clear_done();
    run_sequence(1, 3);
    clear_done();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset = 1'b1; enable = 1'b0; reset_module = 1'b0; ir_in = 1'b0;
    test_reset();
    test_high_freq();
    test_low_freq();
    test_no_ir();
    test_random();
    test_abort();
    test_enable_and_clear();
    test_reset_mid_deploy();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
